regbank_wb_arbiter: RTL

//  Two-requester write-port arbiter and sequencer for the 8x8 register bank.
//  - Sits between the ALU writeback path and the memory-load writeback path, and the bank's single write port.
//  - Generates the bank's split write timing: address/enable in one cycle, data in the next.
//  - Publishes a per-register in-flight scoreboard so decode can stall reads that would return stale data.

---
 rtl/regbank_wb_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/regbank_wb_arbiter.sv
// Write-port arbiter for the register bank: picks ALU or load writeback, then
// drives split address/data write phases and a per-register in-flight scoreboard.
module regbank_wb_arbiter #(
   parameter int DATA_W        = 8,
   parameter int ADDR_W        = 3,
   parameter int NUM_REGS      = 8,
   parameter int PRIORITY_MODE = 0
) (
   input  logic                i_CLK,
   input  logic                i_RST,
   input  logic                i_Hold,
   input  logic                i_AluValid,
   input  logic [ADDR_W-1:0]   i_AluAddr,
   input  logic [DATA_W-1:0]   i_AluData,
   output logic                o_AluReady,
   input  logic                i_MemValid,
   input  logic [ADDR_W-1:0]   i_MemAddr,
   input  logic [DATA_W-1:0]   i_MemData,
   output logic                o_MemReady,
   output logic                o_WriteBack,
   output logic [ADDR_W-1:0]   o_AddrRegDest,
   output logic [DATA_W-1:0]   o_WriteData,
   output logic [NUM_REGS-1:0] o_Busy,
   output logic [7:0]          o_ConflictCnt
);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wreq_t;

   logic                alu_win, alu_gnt, mem_gnt;
   logic [1:0]          vld_pipe_q;    // [0] address phase, [1] data phase
   wreq_t               a_q, a_d;
   logic [ADDR_W-1:0]   b_addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                alu_pri_q;     // round-robin pointer: 1 = ALU wins a tie
   logic [7:0]          cnt_q, cnt_d;
   logic [NUM_REGS-1:0] busy;

   always_comb begin
      alu_win = (PRIORITY_MODE != 0) || alu_pri_q;
      alu_gnt = !i_Hold && i_AluValid && (!i_MemValid || alu_win);
      mem_gnt = !i_Hold && i_MemValid && (!i_AluValid || !alu_win);
      a_d = a_q;
      if (alu_gnt)
         a_d = '{addr: i_AluAddr, data: i_AluData};
      else if (mem_gnt)
         a_d = '{addr: i_MemAddr, data: i_MemData};
   end

   always_comb begin
      cnt_d = cnt_q;
      if (i_AluValid && i_MemValid && !i_Hold && cnt_q != 8'hFF)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         vld_pipe_q <= '0;
         a_q        <= '0;
         b_addr_q   <= '0;
         wdata_q    <= '0;
         alu_pri_q  <= 1'b1;
         cnt_q      <= '0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[0], alu_gnt | mem_gnt};
         a_q        <= a_d;
         cnt_q      <= cnt_d;
         // data phase follows the address phase by one cycle; data holds when idle
         if (vld_pipe_q[0]) begin
            b_addr_q <= a_q.addr;
            wdata_q  <= a_q.data;
         end
         if (alu_gnt)
            alu_pri_q <= 1'b0;
         else if (mem_gnt)
            alu_pri_q <= 1'b1;
      end
   end

   always_comb begin
      busy = '0;
      if (vld_pipe_q[0]) busy[a_q.addr] = 1'b1;
      if (vld_pipe_q[1]) busy[b_addr_q] = 1'b1;
   end

   assign o_AluReady    = alu_gnt;
   assign o_MemReady    = mem_gnt;
   assign o_WriteBack   = vld_pipe_q[0];
   assign o_AddrRegDest = a_q.addr;
   assign o_WriteData   = wdata_q;
   assign o_Busy        = busy;
   assign o_ConflictCnt = cnt_q;

endmodule
